i2c_slave: RTL and testbench

- I2C target (responder) for the 7-bit addressed register-read/write protocol driven by our I2C master.
- Decodes START/STOP, matches its address, accepts a register pointer byte, then accepts write bytes or serves read bytes from a host-side register interface.
- Used as a sensor model on the FCU bench, and as the FCU's own register port when an external controller is the bus master.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_bus_sync.sv | 44 ++++
 rtl/i2c_slave.sv | 170 +++++++++++++++++
 tb/tb_i2c_slave.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and bus constants shared by the I2C target and master
package i2c_pkg;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_REG,
    ST_ACK_REG,
    ST_WDATA,
    ST_ACK_WDATA,
    ST_RDATA,
    ST_MACK
  } i2c_state_e;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronizes scl/sda and flags scl edges plus START/STOP conditions
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [SYNC_STAGES-1:0] scl_q, scl_d, sda_q, sda_d;
  logic scl_p_q, scl_p_d, sda_p_q, sda_p_d, scl_s;
  assign scl_s = scl_q[SYNC_STAGES-1];
  assign sda_s = sda_q[SYNC_STAGES-1];
  // shift raw inputs into the synchronizer chains and keep the last synced value
  always_comb begin
    scl_d   = {scl_q[SYNC_STAGES-2:0], scl_in};
    sda_d   = {sda_q[SYNC_STAGES-2:0], sda_in};
    scl_p_d = scl_s;
    sda_p_d = sda_s;
  end
  // synchronizer flops reset to the idle (pulled-up) bus level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q   <= '1;
      sda_q   <= '1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      scl_p_q <= scl_p_d;
      sda_p_q <= sda_p_d;
    end
  end
  assign scl_rise  = scl_s & ~scl_p_q;
  assign scl_fall  = ~scl_s & scl_p_q;
  assign start_det = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop_det  = scl_s & scl_p_q & ~sda_p_q & sda_s;
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit addressed register target; I2C_SLAVE_AUTOINC_EN enables pointer auto-increment
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h68,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_ptr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       reg_re,
  output logic       busy,
  output logic       bus_error
);
  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d, reg_ptr_q, reg_ptr_d, reg_wdata_q, reg_wdata_d;
  logic seen_q, seen_d, rw_q, rw_d, mack_q, mack_d, sda_oe_q, sda_oe_d;
  logic reg_we_q, reg_we_d, reg_re_q, reg_re_d, busy_q, busy_d, bus_error_q, bus_error_d;
  logic sda_s, scl_rise, scl_fall, start_det, stop_det, byte_end, load_rd;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda), .sda_s(sda_s),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det), .stop_det(stop_det)
  );

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_ptr   = reg_ptr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;
  assign bus_error = bus_error_q;
  // a bit completes on the scl fall that follows its sampling rise
  assign byte_end  = seen_q && bit_cnt_q == 3'd7;

  // next-state logic: bus conditions first, then sample on rise, act on fall
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    seen_d      = seen_q;
    shreg_d     = shreg_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    sda_oe_d    = sda_oe_q;
    reg_ptr_d   = reg_ptr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;
    bus_error_d = bus_error_q;
    load_rd     = 1'b0;
`ifdef I2C_SLAVE_AUTOINC_EN
    if (reg_we_q) reg_ptr_d = reg_ptr_q + 8'd1;
`endif
    if (start_det || stop_det) begin
      bus_error_d = bus_error_q | (bit_cnt_q != 3'd0);
      state_d     = start_det ? ST_ADDR : ST_IDLE;
      bit_cnt_d   = 3'd0;
      seen_d      = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else if (scl_rise) begin
      seen_d = 1'b1;
      if (state_q inside {ST_ADDR, ST_REG, ST_WDATA}) shreg_d = {shreg_q[6:0], sda_s};
      if (state_q == ST_MACK) begin
        mack_d = sda_s;
`ifdef I2C_SLAVE_AUTOINC_EN
        if (sda_s == I2C_ACK) reg_ptr_d = reg_ptr_q + 8'd1;
`endif
      end
    end else if (scl_fall) begin
      seen_d = 1'b0;
      if (seen_q && state_q inside {ST_ADDR, ST_REG, ST_WDATA, ST_RDATA}) bit_cnt_d = bit_cnt_q + 3'd1;
      case (state_q)
        ST_ADDR: if (byte_end) begin
          if (shreg_q[7:1] == SLAVE_ADDR) begin
            state_d     = ST_ACK_ADDR;
            rw_d        = shreg_q[0];
            sda_oe_d    = 1'b1;
            busy_d      = 1'b1;
            bus_error_d = 1'b0;
          end else state_d = ST_IDLE;
        end
        ST_ACK_ADDR: begin
          load_rd  = rw_q == I2C_RW_READ;
          state_d  = ST_REG;
          sda_oe_d = 1'b0;
        end
        ST_REG: if (byte_end) begin
          reg_ptr_d = shreg_q;
          state_d   = ST_ACK_REG;
          sda_oe_d  = 1'b1;
        end
        ST_ACK_REG: begin
          state_d  = ST_WDATA;
          sda_oe_d = 1'b0;
        end
        ST_WDATA: if (byte_end) begin
          state_d  = ST_ACK_WDATA;
          sda_oe_d = 1'b1;
        end
        ST_ACK_WDATA: begin
          reg_wdata_d = shreg_q;
          reg_we_d    = 1'b1;
          state_d     = ST_WDATA;
          sda_oe_d    = 1'b0;
        end
        ST_RDATA: if (byte_end) begin
          state_d  = ST_MACK;
          sda_oe_d = 1'b0;
        end else if (seen_q) begin
          shreg_d  = {shreg_q[6:0], 1'b0};
          sda_oe_d = ~shreg_q[6];
        end
        ST_MACK: begin
          load_rd = mack_q == I2C_ACK;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        default: ;
      endcase
      if (load_rd) begin
        state_d  = ST_RDATA;
        shreg_d  = reg_rdata;
        reg_re_d = 1'b1;
        sda_oe_d = ~reg_rdata[7];
        busy_d   = 1'b1;
      end
    end
  end

  // state and registered outputs; reset releases sda immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      seen_q      <= 1'b0;
      shreg_q     <= 8'd0;
      rw_q        <= I2C_RW_WRITE;
      mack_q      <= I2C_NACK;
      sda_oe_q    <= 1'b0;
      reg_ptr_q   <= 8'd0;
      reg_wdata_q <= 8'd0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      seen_q      <= seen_d;
      shreg_q     <= shreg_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      sda_oe_q    <= sda_oe_d;
      reg_ptr_q   <= reg_ptr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
      bus_error_q <= bus_error_d;
    end
  end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master exercising the register target with directed transfers
module tb_i2c_slave;
  localparam int Q = 10;
  logic clk = 1'b0, rst_n = 1'b0, m_scl = 1'b1, m_sda_oe = 1'b0;
  wire sda;
  logic [7:0] reg_ptr, reg_wdata, reg_rdata, we_ptr, we_data;
  logic reg_we, reg_re, busy, bus_error;
  int n_tests = 0, n_fail = 0, we_cnt = 0, re_cnt = 0;
  logic [7:0] re_log[$];

  always #5 clk = ~clk;
  pullup (sda);
  assign sda = m_sda_oe ? 1'b0 : 1'bz;
  assign reg_rdata = reg_ptr ^ 8'h9E;

  i2c_slave dut (
    .clk(clk), .rst_n(rst_n), .scl(m_scl), .sda(sda), .reg_ptr(reg_ptr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_rdata(reg_rdata), .reg_re(reg_re),
    .busy(busy), .bus_error(bus_error)
  );

  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt  <= we_cnt + 1;
      we_ptr  <= reg_ptr;
      we_data <= reg_wdata;
    end
    if (reg_re) begin
      re_cnt <= re_cnt + 1;
      re_log.push_back(reg_ptr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic quarter(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic wr_bit(input logic b);
    m_sda_oe = ~b;
    quarter(1);
    m_scl = 1'b1;
    quarter(2);
    m_scl = 1'b0;
    quarter(1);
  endtask

  task automatic rd_bit(output logic b);
    m_sda_oe = 1'b0;
    quarter(1);
    m_scl = 1'b1;
    quarter(1);
    b = sda;
    quarter(1);
    m_scl = 1'b0;
    quarter(1);
  endtask

  task automatic start_c;
    m_sda_oe = 1'b0;
    quarter(1);
    m_scl = 1'b1;
    quarter(1);
    m_sda_oe = 1'b1;
    quarter(1);
    m_scl = 1'b0;
    quarter(1);
  endtask

  task automatic stop_c;
    m_sda_oe = 1'b1;
    quarter(1);
    m_scl = 1'b1;
    quarter(1);
    m_sda_oe = 1'b0;
    quarter(2);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(ack);
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(nack);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    logic [7:0] d;
    int we0, re0, q0;
    repeat (3) @(negedge clk);
    check("rst_sda", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_err", bus_error, 0);
    check("rst_ptr", reg_ptr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_we", reg_we, 0);
    check("rst_re", reg_re, 0);
    rst_n = 1'b1;
    quarter(2);

    we0 = we_cnt;
    start_c;
    wr_byte(8'hD0, ack); check("w_addr_ack", ack, 0);
    check("w_busy", busy, 1);
    wr_byte(8'h1B, ack); check("w_reg_ack", ack, 0);
    wr_byte(8'h18, ack); check("w_data_ack", ack, 0);
    stop_c;
    check("w_we_cnt", we_cnt - we0, 1);
    check("w_we_ptr", we_ptr, 8'h1B);
    check("w_we_data", we_data, 8'h18);
    check("w_busy_end", busy, 0);
    check("w_no_err", bus_error, 0);

    we0 = we_cnt; re0 = re_cnt; q0 = re_log.size();
    start_c;
    wr_byte(8'hD0, ack); check("r_waddr_ack", ack, 0);
    wr_byte(8'h3B, ack); check("r_ptr_ack", ack, 0);
    start_c;
    wr_byte(8'hD1, ack); check("r_raddr_ack", ack, 0);
    rd_byte(d, 1'b1);
    check("r_data", d, 8'hA5);
    check("r_sda_rel", sda, 1);
    check("r_busy_nack", busy, 0);
    stop_c;
    check("r_re_cnt", re_cnt - re0, 1);
    check("r_re_ptr", re_log[q0], 8'h3B);
    check("r_no_we", we_cnt - we0, 0);
    check("r_no_err", bus_error, 0);

    we0 = we_cnt; re0 = re_cnt;
    start_c;
    wr_byte(8'hA0, ack); check("x_nack", ack, 1);
    check("x_busy", busy, 0);
    wr_byte(8'h55, ack); check("x_ignore", ack, 1);
    stop_c;
    check("x_no_we", we_cnt - we0, 0);
    check("x_no_re", re_cnt - re0, 0);

    re0 = re_cnt; q0 = re_log.size();
    start_c;
    wr_byte(8'hD0, ack);
    wr_byte(8'hFE, ack); check("b_ptr_ack", ack, 0);
    start_c;
    wr_byte(8'hD1, ack); check("b_addr_ack", ack, 0);
`ifdef I2C_SLAVE_AUTOINC_EN
    rd_byte(d, 1'b0); check("b_d0", d, 8'h60);
    rd_byte(d, 1'b0); check("b_d1", d, 8'h61);
    rd_byte(d, 1'b1); check("b_d2", d, 8'h9E);
    stop_c;
    check("b_re_cnt", re_cnt - re0, 3);
    check("b_p0", re_log[q0], 8'hFE);
    check("b_p1", re_log[q0+1], 8'hFF);
    check("b_p2", re_log[q0+2], 8'h00);
`else
    rd_byte(d, 1'b0); check("b_d0", d, 8'h60);
    rd_byte(d, 1'b1); check("b_d1", d, 8'h60);
    stop_c;
    check("b_re_cnt", re_cnt - re0, 2);
    check("b_p0", re_log[q0], 8'hFE);
    check("b_p1", re_log[q0+1], 8'hFE);
    check("b_ptr_hold", reg_ptr, 8'hFE);
`endif

    we0 = we_cnt;
    start_c;
    wr_byte(8'hD0, ack);
    wr_byte(8'h10, ack); check("e_ptr_ack", ack, 0);
    wr_bit(1'b1); wr_bit(1'b0); wr_bit(1'b1); wr_bit(1'b0);
    stop_c;
    check("e_err", bus_error, 1);
    check("e_no_we", we_cnt - we0, 0);
    check("e_busy", busy, 0);
    check("e_ptr", reg_ptr, 8'h10);
    start_c;
    wr_byte(8'hD0, ack); check("e_re_ack", ack, 0);
    check("e_err_clr", bus_error, 0);
    stop_c;

    start_c;
    for (int i = 7; i >= 0; i--) wr_bit(i inside {7, 6, 4});
    m_sda_oe = 1'b0;
    quarter(1);
    check("z_ack_drv", sda, 0);
    rst_n = 1'b0;
    #1;
    check("z_sda_rel", sda, 1);
    check("z_busy", busy, 0);
    check("z_ptr", reg_ptr, 0);
    check("z_wdata", reg_wdata, 0);
    check("z_err", bus_error, 0);
    m_scl = 1'b1;
    quarter(2);
    rst_n = 1'b1;
    quarter(2);
    check("z_idle_sda", sda, 1);
    check("z_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
